// File: rtl/decision_pkg.sv
// Shared constants for the decision stream: register map, decision and mode
// codes, stream header type, FSM states and the per-class overlay palette.
package decision_pkg;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned CLS_W = 3;

  localparam int unsigned REG_CTRL         = 0;
  localparam int unsigned REG_STATUS       = 1;
  localparam int unsigned REG_DECISION     = 2;
  localparam int unsigned REG_FRAME_CNT    = 3;
  localparam int unsigned REG_CLASS_BASE   = 8;
  localparam int unsigned REG_CLASS_STRIDE = 4;
  localparam int unsigned REG_LO_OFS       = 0;
  localparam int unsigned REG_HI_OFS       = 1;
  localparam int unsigned REG_CNT_OFS      = 2;
  localparam int unsigned REG_XSUM_OFS     = 3;

  localparam logic [3:0] HDR_VIDEO = 4'h0;

  typedef enum logic [1:0] {
    DEC_STOP     = 2'd0,
    DEC_LEFT     = 2'd1,
    DEC_STRAIGHT = 2'd2,
    DEC_RIGHT    = 2'd3
  } decision_e;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_OVERLAY = 2'd1,
    MODE_MASK    = 2'd2,
    MODE_PASS_3  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_VIDEO   = 2'd1,
    ST_CTRLPKT = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic [PIX_W-1:0] class_colour(input logic [CLS_W-1:0] idx);
    case (idx)
      3'd0:    class_colour = 24'hFF0000;
      3'd1:    class_colour = 24'h00FF00;
      3'd2:    class_colour = 24'h0000FF;
      3'd3:    class_colour = 24'hFFFF00;
      3'd4:    class_colour = 24'hFF00FF;
      3'd5:    class_colour = 24'h00FFFF;
      3'd6:    class_colour = 24'hFF8000;
      default: class_colour = 24'h8000FF;
    endcase
  endfunction

endpackage

// File: rtl/decision_classifier.sv
// Box classifier: matches a pixel against NUM_CLASSES inclusive RGB ranges and
// returns the lowest-index hit.
module decision_classifier
  import decision_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 4
) (
  input  rgb_t                              pixel,
  input  logic [NUM_CLASSES-1:0][PIX_W-1:0] lo,
  input  logic [NUM_CLASSES-1:0][PIX_W-1:0] hi,
  output logic                              hit_c,
  output logic [CLS_W-1:0]                  cls_c
);

  rgb_t lo_k;
  rgb_t hi_k;

  // Walk from the top class down so the lowest matching index is left standing.
  always_comb begin
    hit_c = 1'b0;
    cls_c = '0;
    lo_k  = '0;
    hi_k  = '0;
    for (int k = int'(NUM_CLASSES) - 1; k >= 0; k--) begin
      lo_k = rgb_t'(lo[k]);
      hi_k = rgb_t'(hi[k]);
      if ((pixel.r >= lo_k.r) && (pixel.r <= hi_k.r) &&
          (pixel.g >= lo_k.g) && (pixel.g <= hi_k.g) &&
          (pixel.b >= lo_k.b) && (pixel.b <= hi_k.b)) begin
        hit_c = 1'b1;
        cls_c = CLS_W'(k);
      end
    end
  end

endmodule

// File: rtl/decision_stream.sv
// Inline video classifier: per-class count/x-sum per frame and a steering
// decision on the MM slave. DECISION_OVERLAY_EN enables overlay/mask recolouring.
module decision_stream
  import decision_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 4,
  parameter int unsigned IMG_W       = 640,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_chipselect,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [31:0]       s_writedata,
  output logic [31:0]       s_readdata,
  input  logic [23:0]       sink_data,
  input  logic              sink_valid,
  input  logic              sink_sop,
  input  logic              sink_eop,
  output logic              sink_ready,
  output logic [23:0]       source_data,
  output logic              source_valid,
  output logic              source_sop,
  output logic              source_eop,
  input  logic              source_ready,
  input  logic [1:0]        mode
);

  localparam int unsigned X_W       = $clog2(IMG_W);
  localparam int unsigned LEFT_LIM  = IMG_W / 3;
  localparam int unsigned RIGHT_LIM = (2 * IMG_W) / 3;

  typedef logic [NUM_CLASSES-1:0][PIX_W-1:0] thr_arr_t;
  typedef logic [NUM_CLASSES-1:0][31:0]      acc_arr_t;

  state_e            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  acc_arr_t          cnt_q, cnt_d, xs_q, xs_d;
  acc_arr_t          snap_cnt_q, snap_cnt_d, snap_xs_q, snap_xs_d;
  thr_arr_t          lo_sh_q, lo_sh_d, hi_sh_q, hi_sh_d;
  thr_arr_t          lo_wk_q, lo_wk_d, hi_wk_q, hi_wk_d;
  logic              enable_sh_q, enable_sh_d, enable_wk_q, enable_wk_d;
  logic [CLS_W-1:0]  target_sh_q, target_sh_d, target_wk_q, target_wk_d;
  logic [15:0]       min_sh_q, min_sh_d, min_wk_q, min_wk_d;
  logic              frame_done_q, frame_done_d, abort_err_q, abort_err_d;
  decision_e         decision_q, decision_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [PIX_W-1:0]  src_data_q, src_data_d;
  logic              src_valid_q, src_valid_d, src_sop_q, src_sop_d, src_eop_q, src_eop_d;

  logic              hit_c;
  logic [CLS_W-1:0]  cls_c;
  logic [PIX_W-1:0]  pix_xform_c;
  logic              accept_c;
  logic              mm_wr_c;
  acc_arr_t          cnt_upd_c, xs_upd_c;
  logic [32:0]       xs_sum_c;
  logic [31:0]       tgt_cnt_c, tgt_xs_c;
  logic [41:0]       lim_left_c, lim_right_c;
  decision_e         dec_new_c;
  logic [31:0]       rd_mux_c;

  decision_classifier #(.NUM_CLASSES(NUM_CLASSES)) u_classifier (
    .pixel (rgb_t'(sink_data)),
    .lo    (lo_wk_q),
    .hi    (hi_wk_q),
    .hit_c (hit_c),
    .cls_c (cls_c)
  );

  assign sink_ready   = ~reset & (source_ready | ~src_valid_q);
  assign accept_c     = sink_valid & sink_ready;
  assign mm_wr_c      = s_chipselect & s_write;
  assign s_readdata   = rdata_q;
  assign source_data  = src_data_q;
  assign source_valid = src_valid_q;
  assign source_sop   = src_sop_q;
  assign source_eop   = src_eop_q;

`ifdef DECISION_OVERLAY_EN
  // Recolour matched pixels of video payload beats; headers stay untouched.
  always_comb begin
    pix_xform_c = sink_data;
    if ((state_q == ST_VIDEO) && !sink_sop && enable_wk_q) begin
      case (mode)
        MODE_OVERLAY: if (hit_c) pix_xform_c = class_colour(cls_c);
        MODE_MASK:    pix_xform_c = hit_c ? 24'hFFFFFF : 24'h000000;
        default:      pix_xform_c = sink_data;
      endcase
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign pix_xform_c = sink_data;
`endif

  // Register readback mux.
  always_comb begin
    rd_mux_c = '0;
    if (s_address == ADDR_W'(REG_CTRL))      rd_mux_c = {min_sh_q, 12'd0, target_sh_q, enable_sh_q};
    if (s_address == ADDR_W'(REG_STATUS))    rd_mux_c = {30'd0, abort_err_q, frame_done_q};
    if (s_address == ADDR_W'(REG_DECISION))  rd_mux_c = {30'd0, decision_q};
    if (s_address == ADDR_W'(REG_FRAME_CNT)) rd_mux_c = frame_cnt_q;
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      if (s_address == ADDR_W'(REG_CLASS_BASE + REG_CLASS_STRIDE * k + REG_LO_OFS))
        rd_mux_c = {8'd0, lo_sh_q[k]};
      if (s_address == ADDR_W'(REG_CLASS_BASE + REG_CLASS_STRIDE * k + REG_HI_OFS))
        rd_mux_c = {8'd0, hi_sh_q[k]};
      if (s_address == ADDR_W'(REG_CLASS_BASE + REG_CLASS_STRIDE * k + REG_CNT_OFS))
        rd_mux_c = snap_cnt_q[k];
      if (s_address == ADDR_W'(REG_CLASS_BASE + REG_CLASS_STRIDE * k + REG_XSUM_OFS))
        rd_mux_c = snap_xs_q[k];
    end
  end

  // Accumulator update for the current beat and the decision it would yield.
  always_comb begin
    cnt_upd_c = cnt_q;
    xs_upd_c  = xs_q;
    xs_sum_c  = '0;
    tgt_cnt_c = '0;
    tgt_xs_c  = '0;
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      if (enable_wk_q && hit_c && (cls_c == CLS_W'(k))) begin
        cnt_upd_c[k] = (cnt_q[k] == '1) ? cnt_q[k] : cnt_q[k] + 32'd1;
        xs_sum_c     = {1'b0, xs_q[k]} + 33'(x_q);
        xs_upd_c[k]  = xs_sum_c[32] ? '1 : xs_sum_c[31:0];
      end
    end
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      if (target_wk_q == CLS_W'(k)) begin
        tgt_cnt_c = cnt_upd_c[k];
        tgt_xs_c  = xs_upd_c[k];
      end
    end
    lim_left_c  = 42'(tgt_cnt_c) * 42'(LEFT_LIM);
    lim_right_c = 42'(tgt_cnt_c) * 42'(RIGHT_LIM);
    if (tgt_cnt_c < 32'(min_wk_q))          dec_new_c = DEC_STOP;
    else if (42'(tgt_xs_c) < lim_left_c)    dec_new_c = DEC_LEFT;
    else if (42'(tgt_xs_c) > lim_right_c)   dec_new_c = DEC_RIGHT;
    else                                    dec_new_c = DEC_STRAIGHT;
  end

  // Next-state: MM writes, stream FSM, publish and output register.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    cnt_d        = cnt_q;
    xs_d         = xs_q;
    snap_cnt_d   = snap_cnt_q;
    snap_xs_d    = snap_xs_q;
    lo_sh_d      = lo_sh_q;
    hi_sh_d      = hi_sh_q;
    lo_wk_d      = lo_wk_q;
    hi_wk_d      = hi_wk_q;
    enable_sh_d  = enable_sh_q;
    enable_wk_d  = enable_wk_q;
    target_sh_d  = target_sh_q;
    target_wk_d  = target_wk_q;
    min_sh_d     = min_sh_q;
    min_wk_d     = min_wk_q;
    frame_done_d = frame_done_q;
    abort_err_d  = abort_err_q;
    decision_d   = decision_q;
    frame_cnt_d  = frame_cnt_q;
    rdata_d      = rdata_q;
    src_data_d   = src_data_q;
    src_valid_d  = src_valid_q;
    src_sop_d    = src_sop_q;
    src_eop_d    = src_eop_q;

    if (mm_wr_c) begin
      if (s_address == ADDR_W'(REG_CTRL)) begin
        enable_sh_d = s_writedata[0];
        target_sh_d = s_writedata[3:1];
        min_sh_d    = s_writedata[31:16];
      end
      if (s_address == ADDR_W'(REG_STATUS)) begin
        frame_done_d = frame_done_q & ~s_writedata[0];
        abort_err_d  = abort_err_q & ~s_writedata[1];
      end
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        if (s_address == ADDR_W'(REG_CLASS_BASE + REG_CLASS_STRIDE * k + REG_LO_OFS))
          lo_sh_d[k] = s_writedata[PIX_W-1:0];
        if (s_address == ADDR_W'(REG_CLASS_BASE + REG_CLASS_STRIDE * k + REG_HI_OFS))
          hi_sh_d[k] = s_writedata[PIX_W-1:0];
      end
    end

    if (s_chipselect && s_read) rdata_d = rd_mux_c;

    if (accept_c) begin
      src_valid_d = 1'b1;
      src_sop_d   = sink_sop;
      src_eop_d   = sink_eop;
      src_data_d  = pix_xform_c;
      if (sink_sop) begin
        // A header always restarts: an open video frame is dropped unpublished.
        if (state_q == ST_VIDEO) abort_err_d = 1'b1;
        cnt_d       = '0;
        xs_d        = '0;
        x_d         = '0;
        lo_wk_d     = lo_sh_q;
        hi_wk_d     = hi_sh_q;
        enable_wk_d = enable_sh_q;
        target_wk_d = target_sh_q;
        min_wk_d    = min_sh_q;
        src_data_d  = sink_data;
        if (sink_eop)                            state_d = ST_IDLE;
        else if (sink_data[3:0] == HDR_VIDEO)    state_d = ST_VIDEO;
        else                                     state_d = ST_CTRLPKT;
      end else if (state_q == ST_VIDEO) begin
        x_d = (x_q == X_W'(IMG_W - 1)) ? '0 : x_q + X_W'(1);
        if (sink_eop) begin
          snap_cnt_d   = cnt_upd_c;
          snap_xs_d    = xs_upd_c;
          decision_d   = dec_new_c;
          frame_cnt_d  = frame_cnt_q + 32'd1;
          frame_done_d = 1'b1;
          cnt_d        = '0;
          xs_d         = '0;
          x_d          = '0;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_upd_c;
          xs_d  = xs_upd_c;
        end
      end else if ((state_q == ST_CTRLPKT) && sink_eop) begin
        state_d = ST_IDLE;
      end
    end else if (source_ready) begin
      src_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      cnt_q        <= '0;
      xs_q         <= '0;
      snap_cnt_q   <= '0;
      snap_xs_q    <= '0;
      lo_sh_q      <= {NUM_CLASSES{24'hFFFFFF}};
      hi_sh_q      <= '0;
      lo_wk_q      <= {NUM_CLASSES{24'hFFFFFF}};
      hi_wk_q      <= '0;
      enable_sh_q  <= 1'b1;
      enable_wk_q  <= 1'b1;
      target_sh_q  <= '0;
      target_wk_q  <= '0;
      min_sh_q     <= 16'd16;
      min_wk_q     <= 16'd16;
      frame_done_q <= 1'b0;
      abort_err_q  <= 1'b0;
      decision_q   <= DEC_STOP;
      frame_cnt_q  <= '0;
      rdata_q      <= '0;
      src_data_q   <= '0;
      src_valid_q  <= 1'b0;
      src_sop_q    <= 1'b0;
      src_eop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      cnt_q        <= cnt_d;
      xs_q         <= xs_d;
      snap_cnt_q   <= snap_cnt_d;
      snap_xs_q    <= snap_xs_d;
      lo_sh_q      <= lo_sh_d;
      hi_sh_q      <= hi_sh_d;
      lo_wk_q      <= lo_wk_d;
      hi_wk_q      <= hi_wk_d;
      enable_sh_q  <= enable_sh_d;
      enable_wk_q  <= enable_wk_d;
      target_sh_q  <= target_sh_d;
      target_wk_q  <= target_wk_d;
      min_sh_q     <= min_sh_d;
      min_wk_q     <= min_wk_d;
      frame_done_q <= frame_done_d;
      abort_err_q  <= abort_err_d;
      decision_q   <= decision_d;
      frame_cnt_q  <= frame_cnt_d;
      rdata_q      <= rdata_d;
      src_data_q   <= src_data_d;
      src_valid_q  <= src_valid_d;
      src_sop_q    <= src_sop_d;
      src_eop_q    <= src_eop_d;
    end
  end

endmodule
